// File: rtl/cmd_arbiter.sv
// Two-source command arbiter feeding a single drive unit (IDLE/ISSUE/BUSY).
// Define CMD_ARB_RR_EN for round-robin; otherwise UART has fixed priority.
module cmd_arbiter #(
  parameter int CMD_W       = 16,
  parameter int TIMEOUT_CYC = 1000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CMD_W-1:0] uart_cmd,
  input  logic             uart_cmd_rdy,
  output logic             uart_clr,
  input  logic [CMD_W-1:0] tour_cmd,
  input  logic             tour_cmd_rdy,
  output logic             tour_clr,
  output logic [CMD_W-1:0] cmd,
  output logic             cmd_rdy,
  input  logic             clr_cmd_rdy,
  input  logic             send_resp,
  output logic [1:0]       grant,
  output logic             uart_done,
  output logic             tour_done,
  output logic             timeout
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYC);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    BUSY
  } state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [CMD_W-1:0] cmd_n;
  logic [1:0]       grant_n;
  logic             uart_clr_n, tour_clr_n;
  logic             uart_done_n, tour_done_n;
  logic             timeout_n;
  logic             pick_tour;

`ifdef CMD_ARB_RR_EN
  logic last_tour, last_tour_n;

  // On contention, serve whichever source did not win last time.
  assign pick_tour = tour_cmd_rdy &&
                     (!uart_cmd_rdy || !last_tour);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) last_tour <= 1'b1;
    else     last_tour <= last_tour_n;
  end
`else
  assign pick_tour = tour_cmd_rdy && !uart_cmd_rdy;
`endif

  assign cmd_rdy = (state == ISSUE);

  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    cmd_n       = cmd;
    grant_n     = grant;
    uart_clr_n  = 1'b0;
    tour_clr_n  = 1'b0;
    uart_done_n = 1'b0;
    tour_done_n = 1'b0;
    timeout_n   = 1'b0;
`ifdef CMD_ARB_RR_EN
    last_tour_n = last_tour;
`endif
    unique case (state)
      IDLE: begin
        if (uart_cmd_rdy || tour_cmd_rdy) begin
          state_n = ISSUE;
          if (pick_tour) begin
            cmd_n      = tour_cmd;
            grant_n    = 2'b10;
            tour_clr_n = 1'b1;
          end else begin
            cmd_n      = uart_cmd;
            grant_n    = 2'b01;
            uart_clr_n = 1'b1;
          end
`ifdef CMD_ARB_RR_EN
          last_tour_n = pick_tour;
`endif
        end
      end
      ISSUE: begin
        if (clr_cmd_rdy) begin
          if (send_resp) begin
            uart_done_n = grant[0];
            tour_done_n = grant[1];
            grant_n     = 2'b00;
            state_n     = IDLE;
          end else begin
            cnt_n   = '0;
            state_n = BUSY;
          end
        end
      end
      BUSY: begin
        if (send_resp) begin
          uart_done_n = grant[0];
          tour_done_n = grant[1];
          grant_n     = 2'b00;
          state_n     = IDLE;
        end else if (cnt == CNT_LAST) begin
          // This edge brings the count to its limit: abandon.
          cnt_n     = CNT_MAX;
          timeout_n = 1'b1;
          grant_n   = 2'b00;
          state_n   = IDLE;
        end else if (cnt < CNT_MAX) begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      cmd       <= '0;
      grant     <= 2'b00;
      uart_clr  <= 1'b0;
      tour_clr  <= 1'b0;
      uart_done <= 1'b0;
      tour_done <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      cmd       <= cmd_n;
      grant     <= grant_n;
      uart_clr  <= uart_clr_n;
      tour_clr  <= tour_clr_n;
      uart_done <= uart_done_n;
      tour_done <= tour_done_n;
      timeout   <= timeout_n;
    end
  end

endmodule

// File: tb/tb_cmd_arbiter.sv
// Scoreboard bench for cmd_arbiter: stimulus queues expected pops and
// completions, a negedge monitor matches them against DUT pulses.
module tb_cmd_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] uart_cmd = '0;
  logic        uart_cmd_rdy = 1'b0;
  logic        uart_clr;
  logic [15:0] tour_cmd = '0;
  logic        tour_cmd_rdy = 1'b0;
  logic        tour_clr;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic        clr_cmd_rdy = 1'b0;
  logic        send_resp = 1'b0;
  logic [1:0]  grant;
  logic        uart_done;
  logic        tour_done;
  logic        timeout;

  int checks = 0;
  int errors = 0;

  logic [19:0] exp_iss[$];
  logic [4:0]  exp_end[$];
  logic [19:0] iss_e, iss_a;
  logic [4:0]  end_e, end_a;

  cmd_arbiter #(
    .CMD_W(16),
    .TIMEOUT_CYC(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .uart_cmd(uart_cmd),
    .uart_cmd_rdy(uart_cmd_rdy),
    .uart_clr(uart_clr),
    .tour_cmd(tour_cmd),
    .tour_cmd_rdy(tour_cmd_rdy),
    .tour_clr(tour_clr),
    .cmd(cmd),
    .cmd_rdy(cmd_rdy),
    .clr_cmd_rdy(clr_cmd_rdy),
    .send_resp(send_resp),
    .grant(grant),
    .uart_done(uart_done),
    .tour_done(tour_done),
    .timeout(timeout)
  );

  always #5 clk = ~clk;

  // Monitor: every pop pulse and every completion must match the queue head.
  always @(negedge clk) begin
    iss_a = {uart_clr, tour_clr, grant, cmd};
    end_a = {uart_done, tour_done, timeout, grant};
    if (uart_clr || tour_clr) begin
      checks++;
      if (exp_iss.size() == 0) begin
        errors++;
        $display("FAIL issue_unexpected got %h", iss_a);
      end else begin
        iss_e = exp_iss.pop_front();
        if (iss_a !== iss_e) begin
          errors++;
          $display("FAIL issue got %h want %h", iss_a, iss_e);
        end
      end
    end
    if (uart_done || tour_done || timeout) begin
      checks++;
      if (exp_end.size() == 0) begin
        errors++;
        $display("FAIL end_unexpected got %h", end_a);
      end else begin
        end_e = exp_end.pop_front();
        if (end_a !== end_e) begin
          errors++;
          $display("FAIL end got %h want %h", end_a, end_e);
        end
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  task automatic push_iss(bit tour, logic [15:0] c);
    if (tour) exp_iss.push_back({2'b01, 2'b10, c});
    else      exp_iss.push_back({2'b10, 2'b01, c});
  endtask

  // kind: 0 uart_done, 1 tour_done, 2 timeout
  task automatic push_end(int kind);
    case (kind)
      0:       exp_end.push_back(5'b100_00);
      1:       exp_end.push_back(5'b010_00);
      default: exp_end.push_back(5'b001_00);
    endcase
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_grant();
    for (int i = 0; i < 6 && !(uart_clr || tour_clr); i++) tick();
    checks++;
    if (!(uart_clr || tour_clr)) begin
      errors++;
      $display("FAIL grant_wait got none want pop");
    end
    if (uart_clr) uart_cmd_rdy = 1'b0;
    if (tour_clr) tour_cmd_rdy = 1'b0;
    chk("cmd_rdy_issue", 32'(cmd_rdy), 32'd1);
  endtask

  task automatic run_txn(bit tour);
    push_end(tour ? 1 : 0);
    clr_cmd_rdy = 1'b1;
    tick();
    clr_cmd_rdy = 1'b0;
    chk("cmd_rdy_busy", 32'(cmd_rdy), 32'd0);
    tick();
    tick();
    send_resp = 1'b1;
    tick();
    send_resp = 1'b0;
    chk("done", 32'(tour ? tour_done : uart_done), 32'd1);
    chk("grant_idle", 32'(grant), 32'd0);
  endtask

  task automatic serve(bit tour);
    wait_grant();
    run_txn(tour);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tick();
    chk("rst_cmd", 32'(cmd), 32'd0);
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_pulses", 32'({cmd_rdy, uart_clr, tour_clr,
        uart_done, tour_done, timeout}), 32'd0);
    tick();
    rst = 1'b0;
    tick();

    // Single UART transaction
    push_iss(0, 16'h4001);
    uart_cmd = 16'h4001;
    uart_cmd_rdy = 1'b1;
    serve(0);
    tick();
    chk("done_one_cycle", 32'(uart_done), 32'd0);

    // Simultaneous requests from a fresh reset
    do_reset();
    push_iss(0, 16'h4002);
    push_iss(1, 16'h4BF2);
    uart_cmd = 16'h4002;
    tour_cmd = 16'h4BF2;
    uart_cmd_rdy = 1'b1;
    tour_cmd_rdy = 1'b1;
    serve(0);
    serve(1);

    // Both again; UART re-requests right after its pop
    push_iss(0, 16'h4003);
`ifdef CMD_ARB_RR_EN
    push_iss(1, 16'h4004);
    push_iss(0, 16'h4005);
`else
    push_iss(0, 16'h4005);
    push_iss(1, 16'h4004);
`endif
    uart_cmd = 16'h4003;
    tour_cmd = 16'h4004;
    uart_cmd_rdy = 1'b1;
    tour_cmd_rdy = 1'b1;
    serve(0);
    uart_cmd = 16'h4005;
    uart_cmd_rdy = 1'b1;
`ifdef CMD_ARB_RR_EN
    serve(1);
    serve(0);
`else
    serve(0);
    serve(1);
`endif

    // Timeout: 8 cycles after BUSY entry
    push_iss(1, 16'h4BF3);
    tour_cmd = 16'h4BF3;
    tour_cmd_rdy = 1'b1;
    wait_grant();
    clr_cmd_rdy = 1'b1;
    tick();
    clr_cmd_rdy = 1'b0;
    push_end(2);
    for (int k = 1; k < 8; k++) begin
      tick();
      chk("timeout_early", 32'(timeout), 32'd0);
    end
    tick();
    chk("timeout_pulse", 32'(timeout), 32'd1);
    chk("timeout_grant", 32'(grant), 32'd0);
    tick();

    // Accept and respond in the same ISSUE cycle
    push_iss(0, 16'h4006);
    uart_cmd = 16'h4006;
    uart_cmd_rdy = 1'b1;
    wait_grant();
    push_end(0);
    clr_cmd_rdy = 1'b1;
    send_resp = 1'b1;
    tick();
    clr_cmd_rdy = 1'b0;
    send_resp = 1'b0;
    chk("fast_done", 32'(uart_done), 32'd1);
    chk("fast_cmd_rdy", 32'(cmd_rdy), 32'd0);
    chk("fast_grant", 32'(grant), 32'd0);
    tick();
    chk("fast_idle", 32'(cmd_rdy), 32'd0);

    // Asynchronous reset mid-BUSY with a UART request pending
    push_iss(1, 16'h4007);
    tour_cmd = 16'h4007;
    tour_cmd_rdy = 1'b1;
    wait_grant();
    clr_cmd_rdy = 1'b1;
    tick();
    clr_cmd_rdy = 1'b0;
    uart_cmd = 16'h4008;
    uart_cmd_rdy = 1'b1;
    tick();
    #1 rst = 1'b1;
    #1;
    chk("arst_cmd", 32'(cmd), 32'd0);
    chk("arst_grant", 32'(grant), 32'd0);
    chk("arst_pulses", 32'({cmd_rdy, uart_clr, tour_clr,
        uart_done, tour_done, timeout}), 32'd0);
    tick();
    push_iss(0, 16'h4008);
    rst = 1'b0;
    serve(0);

    // Tour held during a UART transaction waits for uart_done
    push_iss(0, 16'h4009);
    push_iss(1, 16'h400A);
    uart_cmd = 16'h4009;
    uart_cmd_rdy = 1'b1;
    wait_grant();
    tour_cmd = 16'h400A;
    tour_cmd_rdy = 1'b1;
    clr_cmd_rdy = 1'b1;
    tick();
    clr_cmd_rdy = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("no_preempt", 32'(tour_clr), 32'd0);
      tick();
    end
    push_end(0);
    send_resp = 1'b1;
    tick();
    send_resp = 1'b0;
    chk("held_udone", 32'(uart_done), 32'd1);
    chk("held_no_pop", 32'(tour_clr), 32'd0);
    tick();
    chk("held_tour_pop", 32'(tour_clr), 32'd1);
    tour_cmd_rdy = 1'b0;
    run_txn(1);

    tick();
    tick();
    chk("iss_left", 32'(exp_iss.size()), 32'd0);
    chk("end_left", 32'(exp_end.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
